// File: rtl/ysyx_25020037_gpr_sb_pkg.sv
// Shared GPR/scoreboard configuration and helpers.
// Optional same-cycle bypass: YSYX_25020037_GPR_BYPASS_EN.
package ysyx_25020037_gpr_sb_pkg;

  localparam int GPR_XLEN    = 32;
  localparam int GPR_NR_REGS = 16;
  localparam int GPR_RD_PRTS = 2;
  localparam int GPR_PEND_W  = 2;

  function automatic int gpr_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int gpr_bus_w(input int ports, input int w);
    return ports * w;
  endfunction

endpackage

// File: rtl/ysyx_25020037_gpr_sb_sb_cnt.sv
// Saturating up/down pending-write counter with clear.
// Simultaneous inc and dec cancel out; clear wins over both.
module ysyx_25020037_sb_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         zero,
  output logic         full
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);
  assign full = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && !dec && !full)
      cnt_d = cnt_q + W'(1);
    else if (dec && !inc && !zero)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ysyx_25020037_gpr_sb.sv
// GPR file with per-register pending-write scoreboard.
// Define YSYX_25020037_GPR_BYPASS_EN for write-back to read bypass.
module ysyx_25020037_gpr_sb
  import ysyx_25020037_gpr_sb_pkg::*;
#(
  parameter  int XLEN        = GPR_XLEN,
  parameter  int NR_REGS     = GPR_NR_REGS,
  parameter  int NR_RD_PORTS = GPR_RD_PRTS,
  parameter  int PEND_W      = GPR_PEND_W,
  localparam int AW          = gpr_aw(NR_REGS)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  iss_valid,
  output logic                                  iss_ready,
  input  logic                                  iss_wen,
  input  logic [AW-1:0]                         iss_rd,
  input  logic [gpr_bus_w(NR_RD_PORTS,AW)-1:0]  rd_addr,
  output logic [gpr_bus_w(NR_RD_PORTS,XLEN)-1:0] rd_data,
  output logic [NR_RD_PORTS-1:0]                rd_busy,
  input  logic                                  wb_valid,
  input  logic                                  wb_wen,
  input  logic [AW-1:0]                         wb_rd,
  input  logic [XLEN-1:0]                       wb_data,
  input  logic                                  flush,
  output logic                                  err_underflow
);

  logic              wb_act;
  logic              iss_acc;
  logic [NR_REGS-1:0] zero_v;
  logic [NR_REGS-1:0] full_v;
  logic [PEND_W-1:0] cnt_v [NR_REGS];
  logic [XLEN-1:0]   regs  [NR_REGS];

  assign wb_act    = wb_valid & wb_wen & (wb_rd != '0);
  assign iss_ready = ~(iss_wen & (iss_rd != '0) & full_v[iss_rd]);
  assign iss_acc   = iss_valid & iss_ready & iss_wen
                   & (iss_rd != '0) & ~flush;

  for (genvar i = 0; i < NR_REGS; i++) begin : g_cnt
    if (i == 0) begin : g_x0
      assign zero_v[i] = 1'b1;
      assign full_v[i] = 1'b0;
      assign cnt_v[i]  = '0;
    end else begin : g_xn
      ysyx_25020037_sb_cnt #(.W(PEND_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (iss_acc & (iss_rd == AW'(i))),
        .dec   (wb_act & (wb_rd == AW'(i))),
        .clr   (flush),
        .cnt   (cnt_v[i]),
        .zero  (zero_v[i]),
        .full  (full_v[i])
      );
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NR_REGS; i++)
        regs[i] <= '0;
    end else if (wb_act) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Flushed write-backs belong to squashed issues, so no underflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err_underflow <= 1'b0;
    else if (wb_act && !flush && zero_v[wb_rd])
      err_underflow <= 1'b1;
  end

  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] d;
    logic            b;
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NR_RD_PORTS; p++) begin
      ra = rd_addr[p*AW +: AW];
      d  = (ra == '0) ? '0 : regs[ra];
      b  = (cnt_v[ra] != '0);
`ifdef YSYX_25020037_GPR_BYPASS_EN
      if (wb_act && (wb_rd == ra)) begin
        d = wb_data;
        if ((cnt_v[ra] == PEND_W'(1)) &&
            !(iss_acc && (iss_rd == ra)))
          b = 1'b0;
      end
`endif
      rd_data[p*XLEN +: XLEN] = d;
      rd_busy[p]              = b;
    end
  end

endmodule

// File: tb/tb_ysyx_25020037_gpr_sb.sv
// Table-driven, scoreboarded bench for ysyx_25020037_gpr_sb.
// Expectations track YSYX_25020037_GPR_BYPASS_EN when defined.
module tb_ysyx_25020037_gpr_sb;

`ifdef YSYX_25020037_GPR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid, iss_ready, iss_wen;
  logic [3:0]  iss_rd;
  logic [7:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wb_valid, wb_wen;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        err_underflow;

  int n_chk = 0;
  int n_fail = 0;

  ysyx_25020037_gpr_sb dut (
    .clk           (clk),
    .rst           (rst),
    .iss_valid     (iss_valid),
    .iss_ready     (iss_ready),
    .iss_wen       (iss_wen),
    .iss_rd        (iss_rd),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_busy       (rd_busy),
    .wb_valid      (wb_valid),
    .wb_wen        (wb_wen),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .flush         (flush),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv, iw;
    logic [3:0]  ird;
    logic        wv;
    logic [3:0]  wrd;
    logic [31:0] wd;
    logic        fl;
    logic [3:0]  a0, a1;
    logic        rdy;
    logic [31:0] d0;
    logic        b0;
    logic [31:0] d1;
    logic        b1;
    logic        err;
  } vec_t;

  typedef struct {
    logic        rdy;
    logic [31:0] d0;
    logic        b0;
    logic [31:0] d1;
    logic        b1;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];

  function automatic vec_t mk(
    input logic iv, iw, input logic [3:0] ird,
    input logic wv, input logic [3:0] wrd,
    input logic [31:0] wd, input logic fl,
    input logic [3:0] a0, a1, input logic rdy,
    input logic [31:0] d0, input logic b0,
    input logic [31:0] d1, input logic b1,
    input logic err);
    vec_t v;
    v.iv = iv; v.iw = iw; v.ird = ird;
    v.wv = wv; v.wrd = wrd; v.wd = wd; v.fl = fl;
    v.a0 = a0; v.a1 = a1; v.rdy = rdy;
    v.d0 = d0; v.b0 = b0; v.d1 = d1; v.b1 = b1;
    v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    iss_valid = v.iv; iss_wen = v.iw; iss_rd = v.ird;
    wb_valid  = v.wv; wb_wen  = v.wv; wb_rd  = v.wrd;
    wb_data   = v.wd; flush   = v.fl;
    rd_addr   = {v.a1, v.a0};
    e.rdy = v.rdy; e.d0 = v.d0; e.b0 = v.b0;
    e.d1 = v.d1; e.b1 = v.b1; e.err = v.err;
    sbq.push_back(e);
  endtask

  task automatic compare(input int idx);
    exp_t e;
    if (sbq.size() == 0) begin
      chk($sformatf("sb_empty[%0d]", idx), 32'd1, 32'd0);
      return;
    end
    e = sbq.pop_front();
    chk($sformatf("ready[%0d]", idx), 32'(iss_ready), 32'(e.rdy));
    chk($sformatf("d0[%0d]", idx), rd_data[31:0], e.d0);
    chk($sformatf("b0[%0d]", idx), 32'(rd_busy[0]), 32'(e.b0));
    chk($sformatf("d1[%0d]", idx), rd_data[63:32], e.d1);
    chk($sformatf("b1[%0d]", idx), 32'(rd_busy[1]), 32'(e.b1));
    chk($sformatf("err[%0d]", idx), 32'(err_underflow), 32'(e.err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(0,0,0, 0,0,0, 0, 4'(i),4'(i),
                        1, 0,0, 0,0, 0));
    vecs.push_back(mk(1,1,5, 0,0,0, 0, 5,0, 1, 0,0, 0,0, 0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0, 5,0, 1, 0,1, 0,0, 0));
    vecs.push_back(mk(0,0,0, 1,5,32'hDEADBEEF, 0, 5,0, 1,
                      BYP ? 32'hDEADBEEF : 32'h0, !BYP, 0,0, 0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0, 5,0, 1,
                      32'hDEADBEEF,0, 0,0, 0));
    vecs.push_back(mk(1,1,3, 0,0,0, 0, 3,0, 1, 0,0, 0,0, 0));
    vecs.push_back(mk(1,1,3, 0,0,0, 0, 3,0, 1, 0,1, 0,0, 0));
    vecs.push_back(mk(1,1,3, 0,0,0, 0, 3,0, 1, 0,1, 0,0, 0));
    vecs.push_back(mk(1,1,3, 0,0,0, 0, 3,0, 0, 0,1, 0,0, 0));
    vecs.push_back(mk(0,1,4, 0,0,0, 0, 3,0, 1, 0,1, 0,0, 0));
    vecs.push_back(mk(0,1,3, 1,3,32'h33, 0, 3,0, 0,
                      BYP ? 32'h33 : 32'h0,1, 0,0, 0));
    vecs.push_back(mk(0,1,3, 0,0,0, 0, 3,0, 1, 32'h33,1, 0,0, 0));
    vecs.push_back(mk(1,1,7, 0,0,0, 0, 0,7, 1, 0,0, 0,0, 0));
    vecs.push_back(mk(1,1,7, 1,7,32'h77, 0, 0,7, 1, 0,0,
                      BYP ? 32'h77 : 32'h0,1, 0));
    vecs.push_back(mk(0,0,0, 1,0,32'h1234, 0, 0,7, 1, 0,0,
                      32'h77,1, 0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0, 0,7, 1, 0,0, 32'h77,1, 0));
    vecs.push_back(mk(1,1,9, 0,0,0, 0, 9,0, 1, 0,0, 0,0, 0));
    vecs.push_back(mk(1,1,9, 0,0,0, 0, 9,0, 1, 0,1, 0,0, 0));
    vecs.push_back(mk(1,1,11, 1,10,32'hAA, 1, 9,3, 1, 0,1,
                      32'h33,1, 0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0, 10,3, 1, 32'hAA,0,
                      32'h33,0, 0));
    vecs.push_back(mk(0,0,0, 1,9,32'h99, 0, 9,11, 1,
                      BYP ? 32'h99 : 32'h0,0, 0,0, 0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0, 9,11, 1, 32'h99,0, 0,0, 1));
    vecs.push_back(mk(1,1,2, 0,0,0, 0, 0,2, 1, 0,0, 0,0, 1));
    vecs.push_back(mk(0,0,0, 1,2,32'hA5A5A5A5, 0, 0,2, 1, 0,0,
                      BYP ? 32'hA5A5A5A5 : 32'h0, !BYP, 1));
    vecs.push_back(mk(0,0,0, 0,0,0, 0, 0,2, 1, 0,0,
                      32'hA5A5A5A5,0, 1));

    rst = 1'b0;
    iss_valid = 0; iss_wen = 0; iss_rd = 0;
    wb_valid = 0; wb_wen = 0; wb_rd = 0; wb_data = 0;
    flush = 0; rd_addr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      @(negedge clk);
      compare(i);
    end

    // Asynchronous reset in the middle of a cycle with work pending.
    @(posedge clk);
    #1;
    iss_valid = 1; iss_wen = 1; iss_rd = 6;
    wb_valid = 0; wb_wen = 0; flush = 0;
    rd_addr = {4'd9, 4'd6};
    @(posedge clk);
    #1;
    iss_valid = 0; iss_wen = 0; iss_rd = 0;
    chk("pre_rst_busy6", 32'(rd_busy[0]), 32'd1);
    chk("pre_rst_err", 32'(err_underflow), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_busy6", 32'(rd_busy[0]), 32'd0);
    chk("rst_data9", rd_data[63:32], 32'd0);
    chk("rst_err", 32'(err_underflow), 32'd0);
    chk("rst_ready", 32'(iss_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rd_addr = {4'd2, 4'd5};
    #1;
    chk("post_rst_d5", rd_data[31:0], 32'd0);
    chk("post_rst_d2", rd_data[63:32], 32'd0);
    chk("post_rst_err", 32'(err_underflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_25020037_gpr_sb.md
Name: ysyx_25020037_gpr_sb

Overview:
Parametrised general-purpose register file with an integrated per-register pending-write scoreboard, for the pipelined core. Decode/issue marks destination registers busy. Write-back retires them. Read ports return data plus a busy flag, so the issue stage can stall on RAW hazards without a separate hazard unit. Replaces the fixed 16x32, two-read-port register file and adds N-port reads, depth/width generics, flush and hazard tracking.

Parameters:
XLEN, 32, data width of each register
NR_REGS, 16, number of architectural registers (16 for RV32E, 32 for RV32I); power of two
NR_RD_PORTS, 2, number of independent combinational read ports (1..4)
PEND_W, 2, width of each per-register pending-write counter; max outstanding writes per register = 2^PEND_W-1

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low
iss_valid  in  1  issue stage presents an instruction
iss_ready  out  1  issue may be accepted this cycle
iss_wen  in  1  issued instruction writes a GPR
iss_rd  in  AW  destination index, AW=$clog2(NR_REGS)
rd_addr  in  NR_RD_PORTS*AW  packed read addresses, port 0 in LSBs
rd_data  out  NR_RD_PORTS*XLEN  packed read data
rd_busy  out  NR_RD_PORTS  per port: register has a pending write, data not yet valid
wb_valid  in  1  write-back stage presents a result
wb_wen  in  1  result targets a GPR
wb_rd  in  AW  write-back destination
wb_data  in  XLEN  write-back data
flush  in  1  pipeline flush: drop all outstanding pending writes
err_underflow  out  1  sticky: write-back seen for a register with zero pending count

Behaviour:
- Reset (rst low, async): all registers 0, all pending counters 0, err_underflow 0. iss_ready and rd_busy are therefore 1 and 0. Reset is legal mid-operation; all in-flight state is discarded.
- Register 0 reads as 0 and is never busy. Writes and issues targeting index 0 are ignored and do not touch counters.
- Read: rd_data[p] = regs[rd_addr[p]]; rd_busy[p] = (pend[rd_addr[p]] != 0). Purely combinational, zero latency.
- Issue accept = iss_valid & iss_ready. iss_ready = 0 only when iss_wen & iss_rd!=0 & pend[iss_rd] == 2^PEND_W-1 (saturated). Otherwise 1.
- On accept with iss_wen & iss_rd!=0: pend[iss_rd] += 1 at the next edge.
- Write-back: wb_valid & wb_wen & wb_rd!=0 writes regs[wb_rd] <= wb_data and decrements pend[wb_rd] at the next edge. Write-backs to one register arrive in issue order. No ready; write-back is always accepted.
- Same-cycle issue and write-back to the same register: counter unchanged, data written.
- Write-back when pend[wb_rd]==0: data is still written, counter stays 0, err_underflow set (held until reset). Suppressed for flushed-cycle write-backs, see below.
- Flush: at the next edge all counters become 0. An issue in the flush cycle is ignored (no increment). A write-back in the flush cycle still writes data and never sets err_underflow.
- Write-back followed by a read in the next cycle returns the new data. Without bypass, a same-cycle read returns old data with busy still set.

Optional Feature:
YSYX_25020037_GPR_BYPASS_EN: when defined, a read port whose address matches an active write-back (wb_valid & wb_wen & wb_rd!=0) returns wb_data. That port's rd_busy is cleared if pend[addr]==1 and no same-cycle issue targets that address; otherwise busy stays as computed. When undefined, reads return only stored state, as specified above.

Decomposition:
- Shared config header (existing core config include) gains: AW derivation macro, GPR_NR_REGS/XLEN defaults, packed-bus width macros for the rd_addr/rd_data buses.
- One sub-module: ysyx_25020037_sb_cnt, a PEND_W-bit up/down counter with async active-low reset, inc/dec/clr inputs, a zero flag and a full flag. Instantiated per register 1..NR_REGS-1 via generate.

Test Plan:
- Reset, then read all ports at indices 0..15 -> data 0, busy 0, iss_ready 1, err_underflow 0.
- Issue wen rd=5, then read port0 addr 5 -> busy 1. Write-back rd=5 data 0xDEADBEEF -> next cycle busy 0, data 0xDEADBEEF.
- PEND_W=2: issue rd=3 three times -> iss_ready 0 for a 4th issue to rd=3, still 1 for rd=4. One write-back to rd=3 -> iss_ready 1.
- Same-cycle issue and write-back rd=7 with pend=1 -> pend stays 1, busy 1, data updated. Write-back rd=0 data 0x1234 -> reads 0.
- Issue rd=9 twice, assert flush -> busy 0 next cycle. A later write-back rd=9 -> err_underflow 1 and stays 1 until rst low.
- With BYPASS_EN, pend[2]=1: write-back rd=2 data 0xA5A5A5A5 while port1 reads 2 -> same-cycle data 0xA5A5A5A5, busy 0. Without BYPASS_EN -> old data, busy 1.
